// File: rtl/mux_2_1_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : mux_2_1_pkg
// Purpose: Shared constants and helpers for the mux_2_1 selector and its
//          optional select-activity counter.
//          - WIDTH_DEFAULT / CNT_W_DEFAULT : default lane and counter widths
//          - LANE0 / LANE1                 : lane indices within the input bus
//          - cnt_max()                     : saturation value of a counter
// Rev    : 1.0  initial release
// ============================================================================
package mux_2_1_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int CNT_W_DEFAULT = 8;

  localparam int LANE0 = 0;
  localparam int LANE1 = 1;

  // All-ones value of a cnt_w-bit counter. Computed in 64 bits so that a
  // 32-bit counter does not overflow the intermediate shift.
  function automatic logic [63:0] cnt_max(input int cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage : mux_2_1_pkg
`default_nettype wire

// File: rtl/mux_2_1_sat_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : sat_counter
// Purpose: Up-counter that increments on inc and holds at its all-ones value
//          instead of wrapping.
// Ports  : clk   - rising-edge clock
//          rst   - asynchronous active-high reset (count -> 0)
//          inc   - increment request for this cycle
//          count - current count, CNT_W bits
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter
  import mux_2_1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Hold at the maximum rather than rolling over to zero.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != C_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/mux_2_1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : mux_2_1
// Purpose: Two-lane selector. z is the lane picked by s, combinationally;
//          z_q is z registered on every rising clk edge. With the macro
//          MUX_2_1_TOGGLE_CNT_EN defined, a saturating counter of s
//          transitions (sampled per clock) is also provided.
// Ports  : clk        - rising-edge clock
//          rst        - asynchronous active-high reset
//          in         - {lane1, lane0}, 2*WIDTH bits
//          s          - select: 0 -> lane0, 1 -> lane1
//          z          - combinational selected lane, WIDTH bits
//          z_q        - registered z, WIDTH bits
//          toggle_cnt - count of sampled s transitions, CNT_W bits
//                       (only with MUX_2_1_TOGGLE_CNT_EN)
// Rev    : 1.0  initial release
// ============================================================================
module mux_2_1
  import mux_2_1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] in,
  input  logic               s,
  output logic [WIDTH-1:0]   z,
  output logic [WIDTH-1:0]   z_q
`ifdef MUX_2_1_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0]   toggle_cnt
`endif
);

  logic [WIDTH-1:0] lane0_w;
  logic [WIDTH-1:0] lane1_w;

  assign lane0_w = in[LANE0*WIDTH +: WIDTH];
  assign lane1_w = in[LANE1*WIDTH +: WIDTH];

  // Plain ternary keeps 4-state merge semantics when s is X/Z; z is
  // independent of clk and rst, so it stays live through reset.
  assign z = s ? lane1_w : lane0_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z;
    end
  end

`ifdef MUX_2_1_TOGGLE_CNT_EN
  // Previous sampled select. Resets to 0, so a select held at 1 across
  // reset release counts as one transition on the first edge.
  logic s_prev_q;
  logic toggle_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s;
    end
  end

  assign toggle_w = (s != s_prev_q);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (toggle_w),
    .count (toggle_cnt)
  );
`else
  // Counter width is only meaningful when the counter is built.
  localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule : mux_2_1
`default_nettype wire

// File: tb/tb_mux_2_1.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module : tb_mux_2_1
// Purpose: Directed self-checking bench for mux_2_1 (WIDTH=1 with CNT_W=2,
//          and a WIDTH=4 instance). Counter checks are built only with
//          MUX_2_1_TOGGLE_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux_2_1;

  logic       clk;
  logic       rst;
  logic [1:0] in1;
  logic       s1;
  logic       z1;
  logic       zq1;
  logic [7:0] in4;
  logic       s4;
  logic [3:0] z4;
  logic [3:0] zq4;
`ifdef MUX_2_1_TOGGLE_CNT_EN
  logic [1:0] cnt1;
  logic [7:0] cnt4;
`endif

  int errors = 0;
  int checks = 0;

  mux_2_1 #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in         (in1),
    .s          (s1),
    .z          (z1),
    .z_q        (zq1)
`ifdef MUX_2_1_TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt1)
`endif
  );

  mux_2_1 #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in         (in4),
    .s          (s4),
    .z          (z4),
    .z_q        (zq4)
`ifdef MUX_2_1_TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed truth table for WIDTH=1: {in, s} -> z
  logic [1:0] tt_in [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
  logic       tt_s  [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
  logic       tt_z  [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

  initial begin
    rst = 1'b1;
    in1 = 2'b00;
    s1  = 1'b0;
    in4 = 8'h00;
    s4  = 1'b0;
    #2;
    chk("reset_zq", 32'(zq1), 32'd0);
`ifdef MUX_2_1_TOGGLE_CNT_EN
    chk("reset_cnt", 32'(cnt1), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive combinational table
    for (int i = 0; i < 8; i++) begin
      in1 = tt_in[i];
      s1  = tt_s[i];
      #0.5;
      chk($sformatf("tt%0d", i), 32'(z1), 32'(tt_z[i]));
    end

    // Sweep: s toggles every 1 ns, in increments every 2 ns, from in=00 s=1
    for (int t = 0; t < 20; t++) begin
      logic [1:0] iv;
      logic       sv;
      iv  = 2'(t / 2);
      sv  = ((t % 2) == 0);
      in1 = iv;
      s1  = sv;
      #0.5;
      chk($sformatf("sweep%0d", t), 32'(z1), 32'(sv ? iv[1] : iv[0]));
      #0.5;
    end

    // Registered path
    @(negedge clk);
    in1 = 2'b10;
    s1  = 1'b1;
    tick();
    chk("reg_zq_1", 32'(zq1), 32'd1);
    #2;
    s1 = 1'b0;
    #0.5;
    chk("reg_z_0", 32'(z1), 32'd0);
    chk("reg_zq_hold", 32'(zq1), 32'd1);
    tick();
    chk("reg_zq_0", 32'(zq1), 32'd0);

    // Async reset between edges
    @(negedge clk);
    s1 = 1'b1;
    tick();
    chk("pre_rst_zq", 32'(zq1), 32'd1);
    #2;
    rst = 1'b1;
    #0.5;
    chk("arst_zq", 32'(zq1), 32'd0);
    chk("arst_z_live", 32'(z1), 32'd1);
`ifdef MUX_2_1_TOGGLE_CNT_EN
    chk("arst_cnt", 32'(cnt1), 32'd0);
`endif

    // Release with s=0 so the counter starts from a clean reference
    @(negedge clk);
    s1  = 1'b0;
    rst = 1'b0;
`ifdef MUX_2_1_TOGGLE_CNT_EN
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      s1 = ~s1;
      tick();
      chk($sformatf("cnt_edge%0d", k), 32'(cnt1), (k > 3) ? 32'd3 : 32'(k));
    end
    // No change on this edge: count must hold at saturation
    tick();
    chk("cnt_hold", 32'(cnt1), 32'd3);
`endif

    // WIDTH=4 lanes
    in4 = 8'hA5;
    s4  = 1'b0;
    #0.5;
    chk("w4_lane0", 32'(z4), 32'h5);
    s4 = 1'b1;
    #0.5;
    chk("w4_lane1", 32'(z4), 32'hA);
    @(negedge clk);
    tick();
    chk("w4_zq", 32'(zq4), 32'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against an unexpected stall in the directed sequence.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mux_2_1
`default_nettype wire
